countdown_timer_param: RTL and testbench

Parameterised loadable down-counter/timer in the sequential primitives library. It is the decrementing counterpart to the library's up-counter. Software or a controller loads a start value, and the block counts down on each enable tick. It then signals expiry with a one-cycle pulse and either stops or auto-reloads. Typical uses are timeouts, fixed-length bursts and periodic tick generation.

---
 rtl/countdown_timer_param.sv | 106 ++++++++++
 tb/tb_countdown_timer_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_param.sv
// ---------------------------------------------------------------------------
// countdown_timer_param
//
// Loadable down-counter/timer. A load sets the count and the reload register.
// Each decrement tick in RUN lowers the count by one. When the count steps
// from 1, the block raises a one-cycle expiry pulse. It then either reloads
// the last loaded value and keeps running, or drops to 0 and goes idle.
//
// Per-edge priority: load_i > stop_i > dec_i.
//
// Ports
//   clk_i         : clock, rising-edge active
//   rstn_i        : asynchronous active-low reset
//   load_i        : load load_value_i into count and reload register
//   load_value_i  : start/reload value (sampled only with load_i)
//   dec_i         : decrement tick (sampled only in RUN)
//   stop_i        : abort countdown, go IDLE holding current count
//   reload_en_i   : on expiry, 1 = reload and continue, 0 = stop at 0
//   value_o       : current count (registered)
//   busy_o        : high while in RUN (registered)
//   expired_o     : one-cycle expiry pulse (registered)
//   zero_o        : value_o == 0 (combinational)
// ---------------------------------------------------------------------------
module countdown_timer_param #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_value_i,
  input  logic                  dec_i,
  input  logic                  stop_i,
  input  logic                  reload_en_i,
  output logic [DATA_WIDTH-1:0] value_o,
  output logic                  busy_o,
  output logic                  expired_o,
  output logic                  zero_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  state_t                state_q,   state_d;
  logic [DATA_WIDTH-1:0] value_q,   value_d;
  logic [DATA_WIDTH-1:0] reload_q,  reload_d;
  logic                  expired_q, expired_d;

  // Next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    value_d   = value_q;
    reload_d  = reload_q;
    expired_d = 1'b0;

    if (load_i) begin
      value_d  = load_value_i;
      reload_d = load_value_i;
      // A zero load parks the timer; RUN is only ever entered with a count >= 1.
      state_d  = (load_value_i != '0) ? RUN : IDLE;
    end else if (stop_i) begin
      state_d = IDLE;
    end else if (state_q == RUN && dec_i) begin
      if (value_q == ONE) begin
        expired_d = 1'b1;
        if (reload_en_i) begin
          // reload_q is nonzero here because RUN required a nonzero load.
          value_d = reload_q;
        end else begin
          value_d = '0;
          state_d = IDLE;
        end
      end else begin
        value_d = value_q - ONE;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rstn_i) begin
      state_q   <= IDLE;
      value_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  assign value_o   = value_q;
  assign busy_o    = (state_q == RUN);
  assign expired_o = expired_q;
  assign zero_o    = (value_q == '0);

endmodule

// File: tb/tb_countdown_timer_param.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer_param
//
// Directed bench for countdown_timer_param. A 32-bit instance covers reset,
// basic countdown, auto-reload, gated decrement, zero load, priority and
// maximum load. A 4-bit instance covers a full countdown from all-ones.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_countdown_timer_param;

  logic clk;
  logic rstn;

  // 32-bit instance
  logic        a_load, a_dec, a_stop, a_reload_en;
  logic [31:0] a_load_value;
  logic [31:0] a_value;
  logic        a_busy, a_expired, a_zero;

  // 4-bit instance
  logic        b_load, b_dec, b_stop, b_reload_en;
  logic [3:0]  b_load_value;
  logic [3:0]  b_value;
  logic        b_busy, b_expired, b_zero;

  int n_cmp = 0;
  int n_err = 0;

  countdown_timer_param #(.DATA_WIDTH(32)) u_dut_a (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .load_i       (a_load),
    .load_value_i (a_load_value),
    .dec_i        (a_dec),
    .stop_i       (a_stop),
    .reload_en_i  (a_reload_en),
    .value_o      (a_value),
    .busy_o       (a_busy),
    .expired_o    (a_expired),
    .zero_o       (a_zero)
  );

  countdown_timer_param #(.DATA_WIDTH(4)) u_dut_b (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .load_i       (b_load),
    .load_value_i (b_load_value),
    .dec_i        (b_dec),
    .stop_i       (b_stop),
    .reload_en_i  (b_reload_en),
    .value_o      (b_value),
    .busy_o       (b_busy),
    .expired_o    (b_expired),
    .zero_o       (b_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [31:0] v, input logic busy,
                         input logic exp_pulse);
    check({tag, ".value"},   a_value,   v);
    check({tag, ".busy"},    32'(a_busy),    32'(busy));
    check({tag, ".expired"}, 32'(a_expired), 32'(exp_pulse));
    check({tag, ".zero"},    32'(a_zero),    32'(v == 32'd0));
  endtask

  initial begin
    int pulses;
    logic [31:0] auto_val [6];
    logic        auto_exp [6];
    logic        gate_dec [4];
    logic [31:0] gate_val [4];

    auto_val = '{32'd1, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2};
    auto_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    gate_dec = '{1'b1, 1'b0, 1'b1, 1'b0};
    gate_val = '{32'd3, 32'd3, 32'd2, 32'd2};

    rstn = 1'b0;
    a_load = 0; a_dec = 0; a_stop = 0; a_reload_en = 0; a_load_value = '0;
    b_load = 0; b_dec = 0; b_stop = 0; b_reload_en = 0; b_load_value = '0;

    // ---- Reset state ----
    #12;
    check_a("reset", 32'd0, 1'b0, 1'b0);
    check("reset_b.zero", 32'(b_zero), 32'd1);
    rstn = 1'b1;

    // ---- Basic countdown, no reload ----
    a_load = 1; a_load_value = 32'd3; a_reload_en = 0;
    tick(); check_a("basic_load", 32'd3, 1'b1, 1'b0);
    a_load = 0; a_dec = 1;
    tick(); check_a("basic_2", 32'd2, 1'b1, 1'b0);
    tick(); check_a("basic_1", 32'd1, 1'b1, 1'b0);
    tick(); check_a("basic_expire", 32'd0, 1'b0, 1'b1);
    tick(); check_a("basic_hold0", 32'd0, 1'b0, 1'b0);
    a_dec = 0;

    // ---- Auto-reload ----
    a_load = 1; a_load_value = 32'd2; a_reload_en = 1;
    tick(); check_a("auto_load", 32'd2, 1'b1, 1'b0);
    a_load = 0; a_dec = 1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_a($sformatf("auto_%0d", i), auto_val[i], 1'b1, auto_exp[i]);
      if (a_expired) pulses++;
    end
    check("auto_pulse_count", 32'(pulses), 32'd3);
    a_dec = 0; a_stop = 1;
    tick(); check_a("auto_stop", 32'd2, 1'b0, 1'b0);
    a_stop = 0; a_dec = 1;
    tick(); check_a("idle_ignores_dec", 32'd2, 1'b0, 1'b0);
    a_dec = 0; a_reload_en = 0;

    // ---- Gated decrement, then zero load ----
    a_load = 1; a_load_value = 32'd4;
    tick(); check_a("gate_load", 32'd4, 1'b1, 1'b0);
    a_load = 0;
    for (int i = 0; i < 4; i++) begin
      a_dec = gate_dec[i];
      tick();
      check_a($sformatf("gate_%0d", i), gate_val[i], 1'b1, 1'b0);
    end
    a_dec = 0; a_load = 1; a_load_value = 32'd0;
    tick(); check_a("zero_load", 32'd0, 1'b0, 1'b0);
    a_load = 0;

    // ---- Priority: load over stop/dec at expiry ----
    a_load = 1; a_load_value = 32'd1;
    tick(); check_a("prio_load1", 32'd1, 1'b1, 1'b0);
    a_load = 1; a_load_value = 32'd9; a_stop = 1; a_dec = 1;
    tick(); check_a("prio_load_wins", 32'd9, 1'b1, 1'b0);
    // ---- Priority: stop over dec at expiry ----
    a_load = 1; a_load_value = 32'd1; a_stop = 0; a_dec = 0;
    tick(); check_a("prio_reload1", 32'd1, 1'b1, 1'b0);
    a_load = 0; a_stop = 1; a_dec = 1;
    tick(); check_a("prio_stop_wins", 32'd1, 1'b0, 1'b0);
    a_stop = 0; a_dec = 0;

    // ---- Maximum load at 32 bits ----
    a_load = 1; a_load_value = 32'hFFFF_FFFF;
    tick(); check_a("max_load", 32'hFFFF_FFFF, 1'b1, 1'b0);
    a_load = 0; a_dec = 1;
    tick(); check_a("max_dec", 32'hFFFF_FFFE, 1'b1, 1'b0);
    a_dec = 0;

    // ---- Asynchronous reset mid-countdown ----
    a_load = 1; a_load_value = 32'd5;
    tick(); check_a("rst_pre", 32'd5, 1'b1, 1'b0);
    a_load = 0; a_dec = 1;
    #2 rstn = 1'b0;
    #1 check_a("async_reset", 32'd0, 1'b0, 1'b0);
    #2 rstn = 1'b1;
    a_dec = 0;
    tick(); check_a("post_reset", 32'd0, 1'b0, 1'b0);

    // ---- 4-bit width edge: 15 down to 0, no wrap ----
    b_load = 1; b_load_value = 4'd15; b_reload_en = 0;
    tick();
    check("w4_load.value", 32'(b_value), 32'd15);
    check("w4_load.busy",  32'(b_busy),  32'd1);
    b_load = 0; b_dec = 1;
    pulses = 0;
    for (int i = 14; i >= 0; i--) begin
      tick();
      check($sformatf("w4_%0d.value", i), 32'(b_value), 32'(i));
      if (b_expired) pulses++;
    end
    check("w4_end.busy",   32'(b_busy),  32'd0);
    check("w4_end.zero",   32'(b_zero),  32'd1);
    check("w4_pulses",     32'(pulses),  32'd1);
    tick();
    check("w4_nowrap.value",   32'(b_value),   32'd0);
    check("w4_nowrap.expired", 32'(b_expired), 32'd0);
    b_dec = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
